// File: rtl/pokey_clk_pkg.sv
// Shared encodings and default divider ratios for the POKEY timebase.
package pokey_clk_pkg;

  typedef logic [1:0] clk_src_t;

  localparam clk_src_t CLK_FAST_SRC = 2'b00;
  localparam clk_src_t CLK_SLOW_SRC = 2'b01;
  localparam clk_src_t CLK_FULL_SRC = 2'b10;
  localparam clk_src_t CLK_OFF_SRC  = 2'b11;

  localparam int DEF_DIV_FAST = 28;
  localparam int DEF_DIV_SLOW = 114;

endpackage

// File: rtl/pokey_tick_divider.sv
// Down-counting tick divider: one-clk tick every DIV enn-qualified edges, all state on negedge clk.
module pokey_tick_divider
  import pokey_clk_pkg::*;
#(
  parameter int DIV   = DEF_DIV_FAST,
  parameter int CNT_W = 7
) (
  input  logic clk,
  input  logic init,
  input  logic enn,
  input  logic reload,
  output logic tick_next,
  output logic tick
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    // A reload restarts the phase and swallows a tick that would land on the same edge.
    if (reload) begin
      cnt_d = LOAD;
    end else if (enn) begin
      if (cnt_q == '0) begin
        cnt_d  = LOAD;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(negedge clk) begin
    if (init) begin
      cnt_q  <= LOAD;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_next = tick_d;
  assign tick      = tick_q;

endmodule

// File: rtl/pokey_clock_gen_multi.sv
// POKEY timebase: fast/slow tick dividers plus per-channel source select and keyboard scan clock.
// Optional macro CLKGEN_RESYNC_EN adds a resync input that restarts both divider phases.
module pokey_clock_gen_multi
  import pokey_clk_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DIV_FAST = DEF_DIV_FAST,
  parameter int DIV_SLOW = DEF_DIV_SLOW,
  parameter int CNT_W    = 7
) (
  input  logic                  clk,
  input  logic                  init,
  input  logic                  enn,
`ifdef CLKGEN_RESYNC_EN
  input  logic                  resync,
`endif
  input  logic [2*NUM_CH-1:0]   ch_sel,
  output logic [NUM_CH-1:0]     aud_tick,
  output logic                  tick_fast,
  output logic                  tick_slow,
  output logic                  keyb_clk
);

  logic reload;
`ifdef CLKGEN_RESYNC_EN
  assign reload = resync;
`else
  assign reload = 1'b0;
`endif

  logic fast_next, slow_next;

  pokey_tick_divider #(.DIV(DIV_FAST), .CNT_W(CNT_W)) u_fast (
    .clk       (clk),
    .init      (init),
    .enn       (enn),
    .reload    (reload),
    .tick_next (fast_next),
    .tick      (tick_fast)
  );

  pokey_tick_divider #(.DIV(DIV_SLOW), .CNT_W(CNT_W)) u_slow (
    .clk       (clk),
    .init      (init),
    .enn       (enn),
    .reload    (reload),
    .tick_next (slow_next),
    .tick      (tick_slow)
  );

  logic [NUM_CH-1:0] aud_tick_q, aud_tick_d;
  logic              keyb_clk_q, keyb_clk_d;

  // Channels pick the divider's next value so they align with tick_fast/tick_slow.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_src_t sel;
    logic     ch_d;
    assign sel = clk_src_t'(ch_sel[2*k +: 2]);
    always_comb begin
      ch_d = 1'b0;
      case (sel)
        CLK_FAST_SRC: ch_d = fast_next;
        CLK_SLOW_SRC: ch_d = slow_next;
        CLK_FULL_SRC: ch_d = enn;
        default:      ch_d = 1'b0;
      endcase
    end
    assign aud_tick_d[k] = ch_d & ~reload;
  end

  assign keyb_clk_d = ~slow_next;

  always_ff @(negedge clk) begin
    if (init) begin
      aud_tick_q <= '0;
      keyb_clk_q <= 1'b1;
    end else begin
      aud_tick_q <= aud_tick_d;
      keyb_clk_q <= keyb_clk_d;
    end
  end

  assign aud_tick = aud_tick_q;
  assign keyb_clk = keyb_clk_q;

endmodule

// File: tb/tb_pokey_clock_gen_multi.sv
// Bench for pokey_clock_gen_multi: phase-count reference model plus directed timing points.
module tb_pokey_clock_gen_multi;

  localparam int NUM_CH = 4;
  localparam int DF     = 28;
  localparam int DS     = 114;

  logic                clk = 1'b0;
  logic                init = 1'b1;
  logic                enn = 1'b1;
  logic                resync = 1'b0;
  logic [2*NUM_CH-1:0] ch_sel = '0;
  logic [NUM_CH-1:0]   aud_tick;
  logic                tick_fast, tick_slow, keyb_clk;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pokey_clock_gen_multi #(.NUM_CH(NUM_CH), .DIV_FAST(DF), .DIV_SLOW(DS), .CNT_W(7)) dut (
    .clk       (clk),
    .init      (init),
    .enn       (enn),
`ifdef CLKGEN_RESYNC_EN
    .resync    (resync),
`endif
    .ch_sel    (ch_sel),
    .aud_tick  (aud_tick),
    .tick_fast (tick_fast),
    .tick_slow (tick_slow),
    .keyb_clk  (keyb_clk)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: count enn-qualified edges since the last phase restart; a tick is due whenever
  // that count is a non-zero multiple of the divide ratio.
  int              nf = 0, ns = 0;
  logic            ef = 0, es = 0, ek = 1, mvalid = 0;
  logic [NUM_CH-1:0] ea = '0;

  always @(negedge clk) begin
    if (init || resync) begin
      nf = 0; ns = 0; ef = 0; es = 0; ea = '0; ek = 1;
      if (init) mvalid = 1;
    end else begin
      ef = 0; es = 0;
      if (enn) begin
        nf++; ns++;
        ef = (nf % DF) == 0;
        es = (ns % DS) == 0;
      end
      for (int k = 0; k < NUM_CH; k++) begin
        case (ch_sel[2*k +: 2])
          2'b00:   ea[k] = ef;
          2'b01:   ea[k] = es;
          2'b10:   ea[k] = enn;
          default: ea[k] = 1'b0;
        endcase
      end
      ek = ~es;
    end
  end

  always @(posedge clk) begin
    if (mvalid) begin
      chk("model_tick_fast", tick_fast, ef);
      chk("model_tick_slow", tick_slow, es);
      chk("model_keyb_clk", keyb_clk, ek);
      chk("model_aud_tick", aud_tick, ea);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_init();
    init = 1'b1;
    repeat (3) begin
      step();
      chk("reset_aud", aud_tick, 0);
      chk("reset_fast", tick_fast, 0);
      chk("reset_slow", tick_slow, 0);
      chk("reset_keyb", keyb_clk, 1);
    end
    init = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: no completion within time limit");
    $fatal(1);
  end

  initial begin
    int cf, ck, c0, c1, c2, c3, first, second;

    // 1/2: reset then defaults, all channels on fast.
    enn = 1'b1; ch_sel = '0;
    do_init();
    cf = 0; ck = 0;
    for (int e = 1; e <= 228; e++) begin
      step();
      cf += tick_fast;
      ck += !keyb_clk;
      if (e == 27)  chk("fast_not_at_27", tick_fast, 0);
      if (e == 28 || e == 56 || e == 84) begin
        chk("fast_at_28k", tick_fast, 1);
        chk("aud_all_at_28k", aud_tick, 4'hF);
      end
      if (e == 113) chk("slow_not_at_113", tick_slow, 0);
      if (e == 114 || e == 228) begin
        chk("slow_at_114j", tick_slow, 1);
        chk("keyb_low_at_114j", keyb_clk, 0);
      end
    end
    chk("fast_count_228", cf, 8);
    chk("keyb_low_count_228", ck, 2);

    // 3: enn toggling 1,0.
    do_init();
    first = -1; second = -1;
    for (int e = 1; e <= 240; e++) begin
      enn = e[0];
      step();
      if (tick_fast) begin
        if (first < 0) first = e;
        else if (second < 0) second = e;
      end
    end
    chk("half_enn_fast_first", first, 55);
    chk("half_enn_fast_period", second - first, 56);
    enn = 1'b1;

    // 4: mixed sources; ch3 OFF, ch2 FULL, ch1 SLOW, ch0 FAST.
    ch_sel = {2'b11, 2'b10, 2'b01, 2'b00};
    do_init();
    c0 = 0; c1 = 0; c2 = 0; c3 = 0;
    for (int e = 1; e <= 1596; e++) begin
      step();
      if (e <= 228) begin
        c0 += aud_tick[0]; c1 += aud_tick[1]; c2 += aud_tick[2]; c3 += aud_tick[3];
      end
      if (e == 1596) chk("coincident_ch0_ch1", aud_tick[1:0], 2'b11);
    end
    chk("mixed_ch0_count", c0, 8);
    chk("mixed_ch1_count", c1, 2);
    chk("mixed_ch2_count", c2, 228);
    chk("mixed_ch3_count", c3, 0);

    // 5: ch0 slow -> fast, change sampled at edge 50.
    ch_sel = {2'b11, 2'b11, 2'b11, 2'b01};
    do_init();
    first = -1;
    for (int e = 1; e <= 114; e++) begin
      if (e == 50) ch_sel[1:0] = 2'b00;
      step();
      if (aud_tick[0] && first < 0) first = e;
      if (e == 114) chk("ch0_none_at_114", aud_tick[0], 0);
    end
    chk("ch0_first_after_switch", first, 56);

`ifdef CLKGEN_RESYNC_EN
    // 6: resync at edge 40, then resync together with init.
    ch_sel = '0;
    do_init();
    for (int e = 1; e <= 160; e++) begin
      resync = (e == 40);
      step();
      if (e == 40) begin
        chk("resync_no_fast", tick_fast, 0);
        chk("resync_keyb", keyb_clk, 1);
      end
      if (e == 67)  chk("resync_fast_not_67", tick_fast, 0);
      if (e == 68)  chk("resync_fast_68", tick_fast, 1);
      if (e == 114) chk("resync_slow_not_114", tick_slow, 0);
      if (e == 154) chk("resync_slow_154", tick_slow, 1);
    end
    resync = 1'b1; init = 1'b1;
    step();
    chk("init_resync_aud", aud_tick, 0);
    chk("init_resync_keyb", keyb_clk, 1);
    resync = 1'b0; init = 1'b0;
`endif

    // Randomized: enn, channel selects, occasional init/resync; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      enn = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) ch_sel = 8'($urandom);
      init = ($urandom_range(0, 499) == 0);
`ifdef CLKGEN_RESYNC_EN
      resync = ($urandom_range(0, 399) == 0);
`endif
      step();
    end
    init = 1'b0; resync = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
